// File: rtl/matvec_engine_if.sv
// Host-side bundle for matvec_engine: operand write ports, start/status and the result stream.
// The host side (master) drives writes, start and result_ready; the engine side (slave) drives results and status.
interface matvec_engine_if #(
  parameter int M          = 3,
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8
);
  localparam int RW = $clog2(M);
  localparam int CW = $clog2(N);

  logic                    start;
  logic                    w_wen;
  logic [RW-1:0]           w_row;
  logic [CW-1:0]           w_col;
  logic [DATA_WIDTH-1:0]   w_in;
  logic                    x_wen;
  logic [CW-1:0]           x_addr;
  logic [DATA_WIDTH-1:0]   x_in;
  logic [2*DATA_WIDTH-1:0] result;
  logic [RW-1:0]           result_idx;
  logic                    result_valid;
  logic                    result_ready;
  logic                    busy;
  logic                    done;

  modport master (
    output start, w_wen, w_row, w_col, w_in, x_wen, x_addr, x_in, result_ready,
    input  result, result_idx, result_valid, busy, done
  );

  modport slave (
    input  start, w_wen, w_row, w_col, w_in, x_wen, x_addr, x_in, result_ready,
    output result, result_idx, result_valid, busy, done
  );
endinterface

// File: rtl/matvec_engine.sv
// Weight-stationary y = W*x engine: N MAC cycles per row, then one saturated result held until accepted.
// Latency (N+1) cycles per row with result_ready high; a low result_ready stalls the engine in EMIT.
module matvec_engine #(
  parameter int M          = 3,
  parameter int N          = 3,
  parameter int DATA_WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  matvec_engine_if.slave  bus
);
  localparam int RW = $clog2(M);
  localparam int CW = $clog2(N);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = PW + CW;

  localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
  localparam logic signed [AW-1:0] SAT_HI = {{(CW + 1){1'b0}}, {(PW - 1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(CW + 1){1'b1}}, {(PW - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

  state_t state;
  state_t state_nxt;

  logic signed [DATA_WIDTH-1:0] w_mem [M][N];
  logic signed [DATA_WIDTH-1:0] x_mem [N];

  logic signed [AW-1:0] acc;
  logic [RW-1:0]        row;
  logic [CW-1:0]        col;
  logic [PW-1:0]        result_q;
  logic [RW-1:0]        result_idx_q;
  logic                 result_valid_q;
  logic                 done_q;

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_sum;
  logic [PW-1:0]        sat_sum;
  logic                 hs;

  // Operand RAMs carry no reset; writes are only taken while idle so a run sees stable data.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (bus.w_wen && bus.w_row <= ROW_LAST && bus.w_col <= COL_LAST)
        w_mem[bus.w_row][bus.w_col] <= bus.w_in;
      if (bus.x_wen && bus.x_addr <= COL_LAST)
        x_mem[bus.x_addr] <= bus.x_in;
    end
  end

  assign prod    = w_mem[row][col] * x_mem[col];
  assign acc_sum = acc + {{CW{prod[PW-1]}}, prod};
  assign hs      = result_valid_q && bus.result_ready;

  always_comb begin
    sat_sum = acc_sum[PW-1:0];
    if (acc_sum > SAT_HI)
      sat_sum = SAT_HI[PW-1:0];
    else if (acc_sum < SAT_LO)
      sat_sum = SAT_LO[PW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = MAC;
      MAC:     if (col == COL_LAST) state_nxt = EMIT;
      EMIT:    if (hs) state_nxt = (row == ROW_LAST) ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc            <= '0;
      row            <= '0;
      col            <= '0;
      result_q       <= '0;
      result_idx_q   <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            acc <= '0;
            row <= '0;
            col <= '0;
          end
        end
        MAC: begin
          if (col == COL_LAST) begin
            result_q       <= sat_sum;
            result_idx_q   <= row;
            result_valid_q <= 1'b1;
            col            <= '0;
          end else begin
            acc <= acc_sum;
            col <= col + 1'b1;
          end
        end
        EMIT: begin
          if (hs) begin
            result_valid_q <= 1'b0;
            if (row == ROW_LAST) begin
              done_q <= 1'b1;
            end else begin
              row <= row + 1'b1;
              col <= '0;
              acc <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result       = result_q;
  assign bus.result_idx   = result_idx_q;
  assign bus.result_valid = result_valid_q;
  assign bus.done         = done_q;
  assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_matvec_engine.sv
// Directed bench for matvec_engine (M=N=3, DW=8): vector table runs plus backpressure, busy and reset sequences.
module tb_matvec_engine;
  localparam int M  = 3;
  localparam int N  = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matvec_engine_if #(.M(M), .N(N), .DATA_WIDTH(DW)) bus ();

  matvec_engine #(.M(M), .N(N), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [71:0] w;  // row-major, element 0 in the top byte
    logic [23:0] x;
    logic [47:0] r;  // expected row results, row 0 in the top halfword
  } vec_t;

  vec_t vecs [5];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int v);
    for (int i = 0; i < M * N; i++) begin
      bus.w_wen = 1'b1;
      bus.w_row = 2'(i / N);
      bus.w_col = 2'(i % N);
      bus.w_in  = vecs[v].w[8*(M*N-1-i) +: 8];
      @(posedge clk); #1;
    end
    bus.w_wen = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.x_wen  = 1'b1;
      bus.x_addr = 2'(i);
      bus.x_in   = vecs[v].x[8*(N-1-i) +: 8];
      @(posedge clk); #1;
    end
    bus.x_wen = 1'b0;
  endtask

  task automatic disturb_set(input logic on);
    bus.start  = on;
    bus.w_wen  = on;
    bus.w_row  = 2'd2;
    bus.w_col  = 2'd2;
    bus.w_in   = 8'd50;
    bus.x_wen  = on;
    bus.x_addr = 2'd2;
    bus.x_in   = 8'd9;
  endtask

  // Edge 0 samples start; row r is expected valid after edge (r+1)*N+r, plus any stall before it.
  task automatic run_check(input int v, input int stall_idx, input int stall_n, input bit disturb);
    int edge_n;
    int n;
    int done_edge;
    int exp_edge;
    logic prev_valid;
    logic [15:0] exp_r;
    edge_n = 0; n = 0; done_edge = -1; prev_valid = 1'b0;
    bus.result_ready = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (done_edge < 0 && edge_n < 200) begin
      @(posedge clk); edge_n++; #1;
      if (edge_n == 1) chk($sformatf("v%0d busy_run", v), bus.busy, 1);
      if (bus.done) begin
        done_edge = edge_n;
        chk($sformatf("v%0d busy_after_done", v), bus.busy, 0);
      end
      if (bus.result_valid && !prev_valid && n < M) begin
        exp_edge = (n + 1) * N + n + ((n > stall_idx) ? stall_n : 0);
        exp_r = vecs[v].r[16*(M-1-n) +: 16];
        chk($sformatf("v%0d row%0d result", v, n), bus.result, exp_r);
        chk($sformatf("v%0d row%0d idx", v, n), bus.result_idx, n);
        chk($sformatf("v%0d row%0d edge", v, n), edge_n, exp_edge);
        if (n == stall_idx) begin
          bus.result_ready = 1'b0;
          repeat (stall_n) begin
            @(posedge clk); edge_n++; #1;
            chk($sformatf("v%0d stall valid", v), bus.result_valid, 1);
            chk($sformatf("v%0d stall result", v), bus.result, exp_r);
            chk($sformatf("v%0d stall idx", v), bus.result_idx, n);
          end
          bus.result_ready = 1'b1;
        end
        n++;
      end
      prev_valid = bus.result_valid;
      if (disturb && edge_n == 2)  disturb_set(1'b1);
      if (disturb && edge_n == 4)  disturb_set(1'b0);
      if (disturb && edge_n == 11) bus.start = 1'b1;
      if (disturb && edge_n == 12) bus.start = 1'b0;
    end
    chk($sformatf("v%0d rows_seen", v), n, M);
    chk($sformatf("v%0d done_edge", v), done_edge, M * (N + 1) + stall_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{w: {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1},
                x: {8'd1, 8'd2, 8'd3}, r: {16'h0001, 16'h0002, 16'h0003}};
    vecs[1] = '{w: {8'hFF, 8'hFE, 8'hFD, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h02},
                x: {8'd4, 8'd5, 8'd6}, r: {16'hFFE0, 16'h0000, 16'h000B}};
    vecs[2] = '{w: {9{8'h7F}}, x: {3{8'h7F}}, r: {3{16'h7FFF}}};
    vecs[3] = '{w: {9{8'h80}}, x: {3{8'h7F}}, r: {3{16'h8000}}};
    vecs[4] = '{w: {8'h7F, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h80, 8'h02, 8'h03, 8'h04},
                x: {3{8'h80}}, r: {16'hC100, 16'h7FFF, 16'hFB80}};

    bus.start = 1'b0; bus.result_ready = 1'b1;
    bus.w_wen = 1'b0; bus.w_row = '0; bus.w_col = '0; bus.w_in = '0;
    bus.x_wen = 1'b0; bus.x_addr = '0; bus.x_in = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset result", bus.result, 0);
    chk("reset idx", bus.result_idx, 0);
    chk("reset valid", bus.result_valid, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      load(v);
      run_check(v, -1, 0, 1'b0);
    end

    // Backpressure: row 1 held for five cycles.
    load(0);
    run_check(0, 1, 5, 1'b0);

    // Busy protection: start and writes mid-run, start again on the final handshake.
    run_check(0, -1, 0, 1'b1);
    @(posedge clk); #1;
    chk("no restart after final handshake", bus.busy, 0);

    // Reset during row 1 MAC, then a clean rerun from retained RAM.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre-reset busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset result", bus.result, 0);
    chk("async reset idx", bus.result_idx, 0);
    chk("async reset valid", bus.result_valid, 0);
    chk("async reset busy", bus.busy, 0);
    chk("async reset done", bus.done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_check(0, -1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
